// File: rtl/bram_reader.sv
// bram_reader: streams LEN consecutive words out of a single-port BSRAM
// onto a valid/ready stream, hiding the fixed read latency.
module bram_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_ad,
    output logic              bram_ce,
    output logic              bram_oce,
    output logic              bram_wre,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last
);

    localparam int FD = RD_LAT + 1;
    localparam int PW = $clog2(FD);
    localparam int CW = $clog2(FD + 1);
    localparam int OW = CW + 1;
    localparam int LW = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     issued_q, issued_d;
    logic [LW-1:0]     sent_q, sent_d;

    logic [RD_LAT-1:0] pipe_q, pipe_d;

    logic [DATA_W-1:0] fifo_q [FD];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [PW-1:0]     wptr_nxt, rptr_nxt;
    logic [CW-1:0]     count_q;

    logic          issue;
    logic          push;
    logic          pop;
    logic          credit;
    logic [OW-1:0] inflight;
    logic [OW-1:0] outstanding;

    assign bram_oce = 1'b1;
    assign bram_wre = 1'b0;
    assign bram_ad  = addr_q;
    assign bram_ce  = issue;

    assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    assign rd_valid = (count_q != '0);
    assign rd_data  = fifo_q[rptr_q];
    assign rd_last  = rd_valid && ((sent_q + LW'(1)) == len_q);

    assign pop  = rd_valid && rd_ready;
    assign push = pipe_q[RD_LAT-1];

    // Count reads still travelling through the BRAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OW'(pipe_q[i]);
        end
    end

    // A word leaving this cycle frees its FIFO slot before the new one lands.
    assign outstanding = inflight + OW'(count_q) - OW'(pop);
    assign credit      = (outstanding < OW'(FD));

    assign issue = (state_q == S_ISSUE) && (issued_q != len_q) && credit;

    // Next-state logic for the burst controller and its counters.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    len_d    = len;
                    issued_d = '0;
                    sent_d   = '0;
                    state_d  = (len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + LW'(1);
                    if ((issued_q + LW'(1)) == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && rd_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
        if (pop) begin
            sent_d = sent_q + LW'(1);
        end
    end

    // Burst controller state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            sent_q   <= sent_d;
        end
    end

    // Tag shift register mirroring the BRAM read latency.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Latency tag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Circular pointer advance for a FIFO depth that need not be 2**n.
    always_comb begin
        wptr_nxt = (wptr_q == PW'(FD - 1)) ? '0 : wptr_q + PW'(1);
        rptr_nxt = (rptr_q == PW'(FD - 1)) ? '0 : rptr_q + PW'(1);
    end

    // Output FIFO: captures bram_dout when a tag exits, first-word fall-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FD; i++) begin
                fifo_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= bram_dout;
                wptr_q         <= wptr_nxt;
            end
            if (pop) begin
                rptr_q <= rptr_nxt;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_bram_reader.sv
// tb_bram_reader: scoreboard bench for bram_reader against a
// behavioural two-stage BSRAM model.
module tb_bram_reader;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_ad;
    logic          bram_ce;
    logic          bram_oce;
    logic          bram_wre;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b1;
    logic          rd_last;

    bram_reader #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .RD_LAT(LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .bram_ad  (bram_ad),
        .bram_ce  (bram_ce),
        .bram_oce (bram_oce),
        .bram_wre (bram_wre),
        .bram_dout(bram_dout),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_last  (rd_last)
    );

    always #5 clk = ~clk;

    // BSRAM model: array read register then output register.
    logic [DW-1:0] mem [8];
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] dout_q = '0;
    assign bram_dout = dout_q;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    end

    always @(posedge clk) begin
        if (bram_ce) q1 <= mem[bram_ad];
        if (bram_oce) dout_q <= q1;
    end

    int vectors = 0;
    int errors = 0;
    int hs_cnt = 0;
    int ce_cnt = 0;
    int done_cnt = 0;
    int outstanding = 0;

    logic [8:0]    exp_q[$];
    logic [AW-1:0] ad_log[$];

    logic          stall_q = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;

    // Monitor: samples 1 time unit after each falling edge.
    always begin
        logic [8:0] e;
        @(negedge clk);
        #1;
        if (!rst_n) begin
            outstanding = 0;
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== hold_data
                    || rd_last !== hold_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             rd_valid, rd_data, rd_last, hold_data, hold_last);
                end
            end
            if (bram_ce) begin
                ce_cnt++;
                ad_log.push_back(bram_ad);
            end
            if (rd_valid && rd_ready) begin
                hs_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got d=%h l=%b want none",
                             rd_data, rd_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({rd_last, rd_data} !== e) begin
                        errors++;
                        $display("FAIL word: got l=%b d=%h want l=%b d=%h",
                                 rd_last, rd_data, e[8], e[7:0]);
                    end
                end
            end
            outstanding = outstanding + int'(bram_ce)
                        - int'(rd_valid && rd_ready);
            if (bram_ce) begin
                vectors++;
                if (outstanding > LAT + 1) begin
                    errors++;
                    $display("FAIL credit: outstanding %0d want <= %0d",
                             outstanding, LAT + 1);
                end
            end
            if (done === 1'b1) done_cnt++;
            stall_q = rd_valid && !rd_ready;
            hold_data = rd_data;
            hold_last = rd_last;
        end
    end

    task automatic push_exp(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0,
                             8'h10 + 8'((base + i) % 8)});
        end
    endtask

    // Leaves the caller at the falling edge of the first cycle after acceptance.
    task automatic pulse_start(input int base, input int n);
        @(negedge clk);
        start = 1'b1;
        base_addr = AW'(base);
        len = (AW + 1)'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rnd,
                                  output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            if (k > 1) @(negedge clk);
            if (rnd) rd_ready = (k < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            #2;
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        rd_ready = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if ({busy, done, rd_valid, rd_last, bram_ce, bram_ad, rd_data} !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %b want all 0",
                     {busy, done, rd_valid, rd_last, bram_ce, bram_ad, rd_data});
        end
        vectors++;
        if ({bram_oce, bram_wre} !== 2'b10) begin
            errors++;
            $display("FAIL const_ports: got oce/wre %b want 10",
                     {bram_oce, bram_wre});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int first_k = -1;
        int last_k = -1;
        int done_k = -1;
        int nvalid = 0;
        int hs0 = hs_cnt;
        int ce0 = ce_cnt;
        logic busy1 = 1'b0;
        logic busy7 = 1'b1;
        push_exp(2, 3);
        @(negedge clk);
        start = 1'b1;
        base_addr = 3'd2;
        len = 4'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            #2;
            if (rd_valid) begin
                nvalid++;
                if (first_k < 0) first_k = k;
                if (rd_last) last_k = k;
            end
            if (done && done_k < 0) done_k = k;
            if (k == 1) busy1 = busy;
            if (k == 7) busy7 = busy;
        end
        vectors++;
        if (first_k !== 4) begin
            errors++;
            $display("FAIL t1_first: got cycle %0d want 4", first_k);
        end
        vectors++;
        if (last_k !== 6 || nvalid !== 3) begin
            errors++;
            $display("FAIL t1_last: got cycle %0d n=%0d want 6 n=3",
                     last_k, nvalid);
        end
        vectors++;
        if (done_k !== 7) begin
            errors++;
            $display("FAIL t1_done: got cycle %0d want 7", done_k);
        end
        vectors++;
        if (busy1 !== 1'b1 || busy7 !== 1'b0) begin
            errors++;
            $display("FAIL t1_busy: got %b%b want 10", busy1, busy7);
        end
        vectors++;
        if (hs_cnt - hs0 != 3 || ce_cnt - ce0 != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL t1_counts: got hs=%0d ce=%0d left=%0d want 3 3 0",
                     hs_cnt - hs0, ce_cnt - ce0, exp_q.size());
        end
    endtask

    task automatic test_wrap;
        int cyc;
        logic [AW-1:0] ea [4];
        ea[0] = 3'd6;
        ea[1] = 3'd7;
        ea[2] = 3'd0;
        ea[3] = 3'd1;
        ad_log.delete();
        push_exp(6, 4);
        pulse_start(6, 4);
        run_until_done(40, 1'b0, cyc);
        vectors++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL t2_done: got cycle %0d want 8", cyc);
        end
        vectors++;
        if (ad_log.size() != 4) begin
            errors++;
            $display("FAIL t2_nissue: got %0d want 4", ad_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (ad_log[i] !== ea[i]) begin
                    errors++;
                    $display("FAIL t2_addr%0d: got %0d want %0d",
                             i, ad_log[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        int hs0 = hs_cnt;
        int d0 = done_cnt;
        push_exp(3, 8);
        pulse_start(3, 8);
        run_until_done(400, 1'b1, cyc);
        @(negedge clk);
        #2;
        vectors++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL t3_timeout: got no done want done");
        end
        vectors++;
        if (hs_cnt - hs0 != 8 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL t3_counts: got hs=%0d left=%0d dn=%0d want 8 0 1",
                     hs_cnt - hs0, exp_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_len0;
        int ce0 = ce_cnt;
        pulse_start(5, 0);
        #2;
        vectors++;
        if ({done, busy, rd_valid} !== 3'b100) begin
            errors++;
            $display("FAIL t4_k1: got done/busy/valid %b want 100",
                     {done, busy, rd_valid});
        end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            #2;
            vectors++;
            if ({done, busy, rd_valid} !== 3'b000) begin
                errors++;
                $display("FAIL t4_k%0d: got %b want 000", k,
                         {done, busy, rd_valid});
            end
        end
        vectors++;
        if (ce_cnt != ce0) begin
            errors++;
            $display("FAIL t4_ce: got %0d issues want 0", ce_cnt - ce0);
        end
    endtask

    task automatic test_restart_ignored;
        int cyc;
        int hs0 = hs_cnt;
        int d0 = done_cnt;
        int ce1;
        logic seen = 1'b0;
        push_exp(1, 5);
        pulse_start(1, 5);
        start = 1'b1;
        base_addr = 3'd0;
        len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        run_until_done(40, 1'b0, cyc);
        start = 1'b1;
        base_addr = 3'd4;
        len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        ce1 = ce_cnt;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (busy || done || rd_valid) seen = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL t5_timeout: got no done want done");
        end
        vectors++;
        if (hs_cnt - hs0 != 5 || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL t5_counts: got hs=%0d dn=%0d left=%0d want 5 1 0",
                     hs_cnt - hs0, done_cnt - d0, exp_q.size());
        end
        vectors++;
        if (seen !== 1'b0 || ce_cnt != ce1) begin
            errors++;
            $display("FAIL t5_done_start: got activity=%b ce=%0d want 0 0",
                     seen, ce_cnt - ce1);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int hs0 = hs_cnt;
        int hs1;
        push_exp(0, 8);
        pulse_start(0, 8);
        for (int k = 0; k < 40; k++) begin
            #2;
            if (hs_cnt - hs0 >= 2) break;
            @(negedge clk);
        end
        vectors++;
        if (hs_cnt - hs0 != 2) begin
            errors++;
            $display("FAIL t6_pre: got %0d words want 2", hs_cnt - hs0);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, rd_valid, rd_last, bram_ce, bram_ad, rd_data} !== '0) begin
            errors++;
            $display("FAIL t6_rst: got %b want all 0",
                     {busy, done, rd_valid, rd_last, bram_ce, bram_ad, rd_data});
        end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hs1 = hs_cnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2;
            vectors++;
            if ({rd_valid, busy, bram_ce} !== 3'b000) begin
                errors++;
                $display("FAIL t6_quiet: got valid/busy/ce %b want 000",
                         {rd_valid, busy, bram_ce});
            end
        end
        push_exp(0, 2);
        pulse_start(0, 2);
        run_until_done(40, 1'b0, cyc);
        vectors++;
        if (cyc != 6 || hs_cnt - hs1 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL t6_after: got cyc=%0d hs=%0d left=%0d want 6 2 0",
                     cyc, hs_cnt - hs1, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0();
        test_restart_ignored();
        test_reset_mid();
        repeat (4) @(negedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
